// File: rtl/f2i_seq.sv
// Sequential 16-bit float (1/8/7, bias 127) to 16-bit signed integer converter.
// It moves the mantissa by one bit per cycle, then rounds toward zero and saturates or zeroes.
module f2i_seq #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;

  state_t state, state_next;

  logic        accept;
  logic        sign;
  logic        left;
  logic        ovf;
  logic        inexact;
  logic [2:0]  cnt;
  logic [15:0] mag;

  // Decode of the incoming operand.
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [6:0]  in_frac;
  logic        ld_left;
  logic [7:0]  ld_dist;
  logic [15:0] ld_mag;
  logic        ld_ovf;
  logic        ld_inexact;
  logic        ld_fin;

  assign in_sign = in_data[15];
  assign in_exp  = in_data[14:7];
  assign in_frac = in_data[6:0];
  assign accept  = in_valid && in_ready;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    ld_left    = (in_exp > 8'd134);
    ld_dist    = ld_left ? (in_exp - 8'd134) : (8'd134 - in_exp);
    ld_mag     = {8'b0, 1'b1, in_frac};
    ld_ovf     = 1'b0;
    ld_inexact = 1'b0;
    ld_fin     = 1'b0;
    if (in_exp == 8'd0) begin
      ld_mag = '0;
      ld_fin = 1'b1;
    end else if (in_exp <= 8'd126) begin
      ld_mag     = '0;
      ld_inexact = 1'b1;
      ld_fin     = 1'b1;
    end else if (in_exp >= 8'd142) begin
      // -32768 is the only exponent-142 value that fits; its magnitude negates to itself.
      if (in_sign && in_exp == 8'd142 && in_frac == 7'd0) ld_mag = 16'h8000;
      else                                                ld_ovf = 1'b1;
      ld_fin = 1'b1;
    end else if (ld_dist == 8'd0) begin
      ld_fin = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept) state_next = ld_fin ? FIN : SHIFT;
      SHIFT: if (cnt == 3'd1) state_next = FIN;
      FIN:   state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign        <= 1'b0;
      left        <= 1'b0;
      ovf         <= 1'b0;
      inexact     <= 1'b0;
      cnt         <= '0;
      mag         <= '0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sign    <= in_sign;
          left    <= ld_left;
          ovf     <= ld_ovf;
          inexact <= ld_inexact;
          cnt     <= ld_dist[2:0];
          mag     <= ld_mag;
        end
        SHIFT: begin
          cnt <= cnt - 3'd1;
          if (left) begin
            mag <= mag << 1;
          end else begin
            mag     <= mag >> 1;
            inexact <= inexact | mag[0];
          end
        end
        FIN: begin
          out_ovf     <= ovf;
          out_inexact <= inexact;
          if (ovf)       out_data <= SATURATE ? (sign ? 16'h8000 : 16'h7FFF) : 16'h0000;
          else if (sign) out_data <= ~mag + 16'd1;
          else           out_data <= mag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f2i_seq.sv
// Scoreboard bench for f2i_seq: the driver queues hand-computed results and a
// negedge monitor checks every presented output, its latency and its stability.
module tb_f2i_seq;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic        inx;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_inexact;
  logic [15:0] in_data, out_data;
  logic        in_valid0, in_ready0, out_valid0, out_ovf0, out_inexact0;
  logic [15:0] out_data0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;

  f2i_seq #(.SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_inexact(out_inexact)
  );

  f2i_seq #(.SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(1'b1), .out_data(out_data0),
    .out_ovf(out_ovf0), .out_inexact(out_inexact0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("data", {16'h0, out_data}, {16'h0, sb[0].data});
        check("ovf", {31'h0, out_ovf}, {31'h0, sb[0].ovf});
        check("inexact", {31'h0, out_inexact}, {31'h0, sb[0].inx});
        if (!seen) check("latency", cyc - acc_cyc, sb[0].lat);
        seen = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic eo,
                      input logic ei, input int el);
    int n = 0;
    exp_t e;
    e.data = ed; e.ovf = eo; e.inx = ei; e.lat = el;
    sb.push_back(e);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
    seen = 1'b0;
  endtask

  task automatic run(input logic [15:0] d, input logic [15:0] ed, input logic eo,
                     input logic ei, input int el);
    send(d, ed, eo, ei, el);
    wait_idle();
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {16'h0, out_data}, 0);
    check("rst_ovf", {31'h0, out_ovf}, 0);
    check("rst_inexact", {31'h0, out_inexact}, 0);
    reset = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 1);

    run(16'h4040, 16'h0003, 1'b0, 1'b0, 7);   //  3.0
    run(16'hC2C8, 16'hFF9C, 1'b0, 1'b0, 2);   // -100.0
    run(16'h3F00, 16'h0000, 1'b0, 1'b1, 1);   //  0.5
    run(16'h4680, 16'h4000, 1'b0, 1'b0, 8);   //  16384.0
    run(16'h4700, 16'h7FFF, 1'b1, 1'b0, 1);   //  32768.0
    run(16'hC700, 16'h8000, 1'b0, 1'b0, 1);   // -32768.0 exact
    run(16'h7F80, 16'h7FFF, 1'b1, 1'b0, 1);   // +inf
    run(16'hFF80, 16'h8000, 1'b1, 1'b0, 1);   // -inf
    run(16'hC701, 16'h8000, 1'b1, 1'b0, 1);   // just below -32768
    run(16'h3F80, 16'h0001, 1'b0, 1'b0, 8);   //  1.0, seven right shifts
    run(16'h3FC0, 16'h0001, 1'b0, 1'b1, 8);   //  1.5, sticky bit
    run(16'hBE80, 16'h0000, 1'b0, 1'b1, 1);   // -0.25
    run(16'h0000, 16'h0000, 1'b0, 1'b0, 1);   // +0
    run(16'h8000, 16'h0000, 1'b0, 1'b0, 1);   // -0
    run(16'h0001, 16'h0000, 1'b0, 1'b0, 1);   // denormal
    run(16'h4300, 16'h0080, 1'b0, 1'b0, 1);   //  128.0, no shift
    run(16'hC6FF, 16'h8080, 1'b0, 1'b0, 8);   // -32640.0

    // Backpressure: result must hold and a second operand must be ignored.
    out_ready = 1'b0;
    send(16'h4040, 16'h0003, 1'b0, 1'b0, 7);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_valid_seen", {31'h0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", {31'h0, in_ready}, 0);
      check("hold_out_valid", {31'h0, out_valid}, 1);
      if (i == 2) begin
        in_valid = 1'b1;
        in_data  = 16'h4000;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle();
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of SHIFT discards the operation.
    in_data = 16'h4040; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", {31'h0, in_ready}, 1);
    check("abort_out_valid", {31'h0, out_valid}, 0);
    repeat (12) @(posedge clk);
    #1;
    run(16'h4000, 16'h0002, 1'b0, 1'b0, 7);   //  2.0

    // Non-saturating instance zeroes overflowed results.
    in_data = 16'h4700; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("nosat_valid", {31'h0, out_valid0}, 1);
    check("nosat_data", {16'h0, out_data0}, 0);
    check("nosat_ovf", {31'h0, out_ovf0}, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f2i_seq.md
F2I_SEQ -- requirements
Module: f2i_seq

Interface
REQ-001 SATURATE, default 1, meaning: 1 clamps out-of-range results to 0x7FFF/0x8000; 0 forces 0x0000 on overflow (out_ovf still asserted).
REQ-002 clk  input  1  rising-edge clock; the single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data holds an operand to convert.
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 in_data  input  16  float: [15] sign, [14:7] exponent (bias 127), [6:0] fraction, hidden leading 1.
REQ-007 out_valid  output  1  out_data and flags are valid.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_data  output  16  two's-complement integer result.
REQ-010 out_ovf  output  1  result was saturated, or forced to 0x0000 when SATURATE=0.
REQ-011 out_inexact  output  1  nonzero fraction bits were discarded.

Function
REQ-012 The block shall have states IDLE, SHIFT, FIN and DONE; in_ready shall be 1 only in IDLE.
REQ-013 An operand shall be accepted on a rising edge where in_valid=1 and in_ready=1; in_data shall be ignored at every other time.
REQ-014 On accept, it shall latch the sign, set E=exponent and load mag={8'b0,1,fraction}.
REQ-015 On accept, the shift count shall be n=|E-134|, with direction right if E<134 and left if E>134.
REQ-016 Special case, E=0: mag=0, flags 0 (denormals treated as zero), next state FIN.
REQ-017 Special case, 1<=E<=126: mag=0, inexact=1, next state FIN.
REQ-018 Special case, E>=142, except sign=1, E=142, fraction=0: overflow, ovf=1, next state FIN (includes E=255 inf/NaN, using the latched sign).
REQ-019 Special case, sign=1, E=142, fraction=0: exact -32768, out_data=0x8000, ovf=0.
REQ-020 For all other operands with n=0, the next state shall be FIN; otherwise it shall be SHIFT with cnt=n.
REQ-021 In SHIFT, each cycle shall shift mag one bit in the latched direction and decrement cnt; state shall go to FIN on the edge where cnt reaches 0.
REQ-022 Any 1 bit shifted out of mag[0] during a right shift shall set sticky inexact.
REQ-023 In FIN, on overflow, out_data shall be 0x7FFF if positive or 0x8000 if negative when SATURATE=1, and 0x0000 when SATURATE=0.
REQ-024 In FIN, otherwise, out_data shall be mag if positive or (~mag+1) if negative; a negative zero result shall be 0x0000.
REQ-025 In FIN, out_valid shall be set and state shall go to DONE.
REQ-026 Latency shall be exactly n+1 cycles from the accepting edge to out_valid=1, with n=0 for special cases.
REQ-027 In DONE, out_valid, out_data and flags shall hold stable until an edge with out_ready=1, then clear out_valid and return to IDLE.
REQ-028 A new operand shall be accepted no earlier than the cycle after that return to IDLE; there shall be no overlap.
REQ-029 out_ready shall be ignored while out_valid=0.

Reset
REQ-030 While reset=1 at a rising edge, state shall go to IDLE and out_valid, out_data, out_ovf and out_inexact shall all be 0.
REQ-031 In the cycle after the reset edge, in_ready shall be 1.
REQ-032 Reset asserted during SHIFT, FIN or DONE shall abort the operation and discard the pending result without any out_valid pulse; reset shall take priority over an accept on the same edge.

Verification
REQ-033 0x4040 (3.0), out_ready=1 -> 0x0003, ovf=0, inexact=0, out_valid 7 cycles after accept.
REQ-034 0xC2C8 (-100.0) -> 0xFF9C after 2 cycles; 0x3F00 (0.5) -> 0x0000, inexact=1, after 1 cycle.
REQ-035 0x4680 (16384.0) -> 0x4000 after 8 cycles (7 left shifts); 0x4700 -> 0x7FFF, ovf=1; 0xC700 -> 0x8000, ovf=0; 0x7F80 -> 0x7FFF, ovf=1.
REQ-036 out_ready held 0 for 5 cycles after out_valid -> out_valid and out_data stable, in_ready=0; in_valid pulsed with a second operand is not accepted.
REQ-037 reset asserted mid-SHIFT on 0x4040 -> next cycle in_ready=1, out_valid=0; the next operand 0x4000 -> 0x0002.
REQ-038 SATURATE=0, 0x4700 -> 0x0000, ovf=1.
